// File: rtl/dm_table_seq.sv
// ---------------------------------------------------------------------------
// dm_table_seq
//
// Table sequencer that sweeps one 16-entry bank of a small table living in
// the shared data memory. A clear operation writes Fill into every entry of
// the bank; a checksum operation reads every entry and accumulates a W-bit
// wrapping sum. The core always has priority on the data memory port, so
// the sweep simply stalls on any cycle where CoreReq is high.
//
// Table layout: bank b occupies addresses 72 + 16*b .. 87 + 16*b, and only
// banks 0 and 1 exist. A Start naming any other bank is rejected with a
// one-cycle Err pulse.
//
// Ports:
//   Clk       system clock, all state changes on the rising edge
//   Reset     synchronous active-high reset
//   Start     request an operation (only looked at while idle)
//   Op        0 = clear bank, 1 = checksum bank
//   Bank      bank select (0 or 1)
//   Fill      value written by a clear operation
//   CoreReq   core claims the data memory this cycle
//   DmRdData  data memory read data, combinational from DmAddr
//   DmSel     sequencer owns the data memory port this cycle
//   DmAddr    data memory address (0 whenever DmSel is low)
//   DmWrEn    data memory write enable
//   DmWrData  data memory write data
//   Busy      high for the whole sweep
//   Done      one-cycle pulse after the last access
//   Err       one-cycle pulse after a rejected Start
//   Sum       checksum result, held until the next accepted Start
// ---------------------------------------------------------------------------
module dm_table_seq #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Op,
    input  logic [W-1:0] Bank,
    input  logic [W-1:0] Fill,
    input  logic         CoreReq,
    input  logic [W-1:0] DmRdData,
    output logic         DmSel,
    output logic [9:0]   DmAddr,
    output logic         DmWrEn,
    output logic [W-1:0] DmWrData,
    output logic         Busy,
    output logic         Done,
    output logic         Err,
    output logic [W-1:0] Sum
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seqStateT;

    localparam logic [9:0] TABLE_BASE = 10'd72;
    localparam logic [3:0] LAST_IDX   = 4'd15;

    seqStateT     state;
    seqStateT     nextState;

    logic         opReg;
    logic         bankReg;
    logic [W-1:0] fillReg;
    logic [3:0]   idx;
    logic [W-1:0] sumReg;
    logic         errReg;

    logic         bankOk;
    logic         accept;
    logic         reject;
    logic         step;
    logic [9:0]   entryAddr;

    // Only banks 0 and 1 exist, so any set bit above bit 0 makes the
    // request illegal. The captured bank is therefore a single bit.
    assign bankOk = (Bank[W-1:1] == '0);

    // Entry address of the current sweep position: the bank bit lands on
    // address bit 4, which is exactly the 16-entry bank stride.
    assign entryAddr = TABLE_BASE + {5'd0, bankReg, 4'd0} + {6'd0, idx};

    assign Err = errReg;
    assign Sum = sumReg;

    // State register. Reset returns to IDLE regardless of Start, which also
    // aborts a sweep in progress before any further memory access.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode. The memory port is driven only while
    // sweeping and the core is not claiming it; otherwise every port output
    // is forced to zero. The sweep ends on the access at the last index, so
    // the index never gets a chance to wrap into a seventeenth access.
    always_comb begin
        nextState = state;
        DmSel     = 1'b0;
        DmAddr    = '0;
        DmWrEn    = 1'b0;
        DmWrData  = '0;
        Busy      = 1'b0;
        Done      = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (bankOk) begin
                        accept    = 1'b1;
                        nextState = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (!CoreReq) begin
                    step     = 1'b1;
                    DmSel    = 1'b1;
                    DmAddr   = entryAddr;
                    DmWrEn   = ~opReg;
                    DmWrData = opReg ? '0 : fillReg;
                    if (idx == LAST_IDX) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath registers. An accepted Start snapshots the request so later
    // changes on Op/Bank/Fill cannot disturb the sweep, and clears the index
    // and the running sum. Each granted access advances the index and, for a
    // checksum, folds the read data into the wrapping sum. A stall cycle
    // leaves everything untouched. The error flag is a registered copy of
    // the reject decision, which gives the one-cycle pulse after a bad Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            opReg   <= 1'b0;
            bankReg <= 1'b0;
            fillReg <= '0;
            idx     <= '0;
            sumReg  <= '0;
            errReg  <= 1'b0;
        end else begin
            errReg <= reject;
            if (accept) begin
                opReg   <= Op;
                bankReg <= Bank[0];
                fillReg <= Fill;
                idx     <= '0;
                sumReg  <= '0;
            end else if (step) begin
                idx <= idx + 4'd1;
                if (opReg) begin
                    sumReg <= sumReg + DmRdData;
                end
            end
        end
    end

endmodule

// File: doc/dm_table_seq.md
DM_TABLE_SEQ -- requirements
Module: dm_table_seq

Interface
REQ-001 Parameter: W, default 8, data path width.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request a table operation; sampled only in IDLE.
REQ-005 Op  input  1  0 = clear bank (write Fill to all 16 entries); 1 = checksum bank (read and sum all 16 entries).
REQ-006 Bank  input  W  table bank select; legal values 0 and 1 only.
REQ-007 Fill  input  W  value written by a clear operation.
REQ-008 CoreReq  input  1  core claims data memory this cycle; core has priority.
REQ-009 DmRdData  input  W  data memory read data; combinational from DmAddr.
REQ-010 DmSel  output  1  sequencer owns the data memory port this cycle.
REQ-011 DmAddr  output  10  data memory address.
REQ-012 DmWrEn  output  1  data memory write enable.
REQ-013 DmWrData  output  W  data memory write data.
REQ-014 Busy  output  1  operation in progress.
REQ-015 Done  output  1  one-cycle pulse at operation completion.
REQ-016 Err  output  1  one-cycle pulse on rejected Start.
REQ-017 Sum  output  W  checksum result; holds until the next accepted Start.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 In IDLE with Start=1 and Bank<=1, the block SHALL capture Op, Bank and Fill, clear idx to 0 and Sum to 0, and enter RUN on the next edge.
REQ-020 In IDLE with Start=1 and Bank>1, the block SHALL pulse Err for exactly one cycle on the following cycle, remain in IDLE and leave Sum unchanged.
REQ-021 Start SHALL be ignored in RUN and DONE, with no effect on captured values.
REQ-022 The entry address SHALL be 72 + 16*Bank + idx (bank 0 = 72..87, bank 1 = 88..103), computed as a 10-bit value.
REQ-023 In RUN with CoreReq=0: DmSel=1, DmAddr=entry address, and idx SHALL increment by 1.
REQ-024 In RUN with CoreReq=0 and Op=0: DmWrEn=1 and DmWrData=captured Fill.
REQ-025 In RUN with CoreReq=0 and Op=1: DmWrEn=0 and Sum SHALL update to (Sum + DmRdData) mod 2^W.
REQ-026 In RUN with CoreReq=1, the block SHALL stall: DmSel=0, DmWrEn=0, and idx and Sum held.
REQ-027 When DmSel=0, DmAddr, DmWrEn and DmWrData SHALL all be 0.
REQ-028 The access at idx=15 SHALL complete the sweep; the FSM SHALL then enter DONE, and idx SHALL not wrap into a 17th access.
REQ-029 Busy SHALL equal 1 exactly while in RUN.
REQ-030 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-031 With no stalls, Start accepted at cycle t SHALL produce accesses in cycles t+1..t+16 and Done in cycle t+17; each stall cycle adds one cycle of latency.
REQ-032 Sum SHALL hold its value after Done until the next accepted Start.

Reset
REQ-033 While Reset=1, the block SHALL enter IDLE on the clock edge, setting idx=0, Sum=0, and Busy, Done, Err, DmSel and DmWrEn to 0.
REQ-034 Reset asserted mid-operation SHALL abort the sweep, with no data memory write in any cycle after the reset edge.
REQ-035 Reset SHALL take priority over Start in the same cycle.

Verification
REQ-036 Clear bank 0: Op=0, Bank=0, Fill=8'hA5, CoreReq=0 -> writes of A5 to addresses 72..87 in 16 consecutive cycles; Done at t+17; address 88 untouched.
REQ-037 Checksum bank 1: memory 88..103 preloaded with 1..16 -> Sum=136 (8'h88) at Done, held afterwards.
REQ-038 Checksum wrap: bank 0 entries all 8'hFF -> Sum=8'hF0.
REQ-039 Stalls: CoreReq=1 for 3 cycles during RUN -> DmSel=0 and DmWrEn=0 in those cycles; no address skipped or repeated; Done at t+20.
REQ-040 Bad bank: Start with Bank=2 -> Err pulses once, Busy stays 0, no DmSel asserted.
REQ-041 Reset during clear at idx=5 -> only 72..77 written; outputs 0 the next cycle; a following Start runs normally from idx 0.
